crc_frame_filter: RTL

Store-and-forward frame filter sitting directly downstream of the receive-mode CRC16Par32Poly0x1021 checker (FlagTR=0). Buffers each received frame (32-bit words with byte keep and last) until the checker reports the CRC verdict. It then releases good frames to the consumer with valid/ready flow control and discards bad, truncated or timed-out frames. The consumer therefore only ever sees CRC-clean frames.

---
 rtl/crc_frame_pkg.sv | 21 ++
 rtl/crc_frame_ram.sv | 23 ++
 rtl/crc_frame_filter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/crc_frame_pkg.sv
// crc_frame_pkg: shared widths and types for the CRC frame filter.
// Optional statistics are enabled with CRC_FRAME_STATS_EN.
package crc_frame_pkg;
  localparam int WORD_W = 32;
  localparam int KEEP_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DROP,
    WAIT_CHK
  } wrState_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } ramEntry_t;

  localparam int ENTRY_W = $bits(ramEntry_t);
endpackage

// File: rtl/crc_frame_ram.sv
// crc_frame_ram: simple dual-port RAM with a registered read port.
// Read data holds its value while re is low.
module crc_frame_ram
  import crc_frame_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wAddr,
  input  logic [WIDTH-1:0]         wData,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] rAddr,
  output logic [WIDTH-1:0]         rData
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wAddr] <= wData;
    if (re) rData <= mem[rAddr];
  end
endmodule

// File: rtl/crc_frame_filter.sv
// crc_frame_filter: store-and-forward buffer releasing only CRC-good frames.
// Define CRC_FRAME_STATS_EN to enable the GoodCnt/BadCnt/OvfCnt counters.
module crc_frame_filter
  import crc_frame_pkg::*;
#(
  parameter int DEPTH_WORDS = 512,
  parameter int CHK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              SyncIn,
  input  logic              DinNd,
  input  logic [WORD_W-1:0] Din,
  input  logic [KEEP_W-1:0] DinKeep,
  input  logic              DinLast,
  input  logic              CheckSync,
  input  logic              CheckCRC,
  input  logic              DoutRdy,
  output logic              DoutNd,
  output logic [WORD_W-1:0] Dout,
  output logic [KEEP_W-1:0] DoutKeep,
  output logic              DoutLast,
  output logic              SyncOut,
  output logic              FrameDrop,
  output logic              Overflow,
  output logic [15:0]       GoodCnt,
  output logic [15:0]       BadCnt,
  output logic [15:0]       OvfCnt
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(CHK_TIMEOUT) + 1;
  localparam logic [PW-1:0] FULL_GAP = PW'(DEPTH_WORDS);
  localparam logic [TW-1:0] TMR_LAST = TW'(CHK_TIMEOUT - 1);

  wrState_t st, stN;
  logic [PW-1:0] wrPtr, wrPtrN;
  logic [PW-1:0] wrCommit, wrCommitN;
  logic [PW-1:0] rdPtr;
  logic [TW-1:0] tmr, tmrN;
  logic ovfF, ovfFN;
  logic start, used;
  logic we;
  logic [AW-1:0] wAddr;
  ramEntry_t wEntry, rEntry;
  logic dropP, ovfP, goodP, badP;

  assign start = SyncIn && DinNd;

  always_comb begin
    stN = st;
    wrPtrN = wrPtr;
    wrCommitN = wrCommit;
    ovfFN = ovfF;
    we = 1'b0;
    wAddr = wrPtr[AW-1:0];
    wEntry = '{data: Din, keep: (DinLast ? DinKeep : 4'hF), last: DinLast};
    dropP = 1'b0;
    ovfP = 1'b0;
    goodP = 1'b0;
    badP = 1'b0;
    used = 1'b0;
    // Resolve pending verdicts and aborts before accepting this cycle's word.
    if (st == WAIT_CHK) begin
      if (CheckSync) begin
        used = 1'b1;
        if (CheckCRC && !ovfF) begin
          wrCommitN = wrPtr;
          goodP = 1'b1;
        end else begin
          wrPtrN = wrCommit;
          dropP = 1'b1;
          badP = !CheckCRC;
        end
        stN = IDLE;
      end else if (tmr == TMR_LAST || start) begin
        wrPtrN = wrCommit;
        dropP = 1'b1;
        stN = IDLE;
      end
    end else if (st != IDLE && start) begin
      wrPtrN = wrCommit;
      dropP = 1'b1;
      stN = IDLE;
    end
    if (DinNd && (stN == WRITE || (stN == IDLE && SyncIn))) begin
      if (stN == IDLE) ovfFN = 1'b0;
      if (wrPtrN - rdPtr == FULL_GAP) begin
        ovfP = 1'b1;
        ovfFN = 1'b1;
        stN = DinLast ? WAIT_CHK : DROP;
      end else begin
        we = 1'b1;
        wAddr = wrPtrN[AW-1:0];
        wrPtrN = wrPtrN + PW'(1);
        stN = DinLast ? WAIT_CHK : WRITE;
      end
    end else if (DinNd && DinLast && stN == DROP) begin
      stN = WAIT_CHK;
    end
    // A verdict arriving with the closing word applies to that frame.
    if (stN == WAIT_CHK && CheckSync && !used) begin
      if (CheckCRC && !ovfFN) begin
        wrCommitN = wrPtrN;
        goodP = 1'b1;
      end else begin
        wrPtrN = wrCommitN;
        dropP = 1'b1;
        badP = !CheckCRC;
      end
      stN = IDLE;
    end
    tmrN = (st == WAIT_CHK && stN == WAIT_CHK) ? tmr + TW'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (!Rst) begin
      st <= IDLE;
      wrPtr <= '0;
      wrCommit <= '0;
      tmr <= '0;
      ovfF <= 1'b0;
      FrameDrop <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      st <= stN;
      wrPtr <= wrPtrN;
      wrCommit <= wrCommitN;
      tmr <= tmrN;
      ovfF <= ovfFN;
      FrameDrop <= dropP;
      Overflow <= ovfP;
    end
  end

  logic re, rv, push, pop, sofNext;
  logic outV, spV;
  logic [ENTRY_W:0] outR, spR, inW;

  crc_frame_ram #(.DEPTH(DEPTH_WORDS), .WIDTH(ENTRY_W)) uRam (
    .clk  (clk),
    .we   (we),
    .wAddr(wAddr),
    .wData(wEntry),
    .re   (re),
    .rAddr(rdPtr[AW-1:0]),
    .rData(rEntry)
  );

  // RAM data register acts as a third slot so re never depends on DoutRdy.
  assign re = (rdPtr != wrCommit) && (!rv || !spV);
  assign push = rv && !spV;
  assign pop = outV && DoutRdy;
  assign inW = {sofNext, rEntry};

  always_ff @(posedge clk) begin
    if (!Rst) begin
      rdPtr <= '0;
      rv <= 1'b0;
      sofNext <= 1'b1;
      outV <= 1'b0;
      spV <= 1'b0;
      outR <= '0;
      spR <= '0;
    end else begin
      if (re) rdPtr <= rdPtr + PW'(1);
      rv <= re || (rv && !push);
      if (push) sofNext <= rEntry.last;
      if (pop && spV) begin
        outR <= spR;
        spV <= 1'b0;
      end else if (pop || !outV) begin
        outV <= push;
        if (push) outR <= inW;
      end else if (push) begin
        spR <= inW;
        spV <= 1'b1;
      end
    end
  end

  assign DoutNd = outV;
  assign Dout = outR[ENTRY_W-1 -: WORD_W];
  assign DoutKeep = outR[KEEP_W:1];
  assign DoutLast = outV && outR[0];
  assign SyncOut = outV && outR[ENTRY_W];

`ifdef CRC_FRAME_STATS_EN
  always_ff @(posedge clk) begin
    if (!Rst) begin
      GoodCnt <= '0;
      BadCnt <= '0;
      OvfCnt <= '0;
    end else begin
      if (goodP && GoodCnt != 16'hFFFF) GoodCnt <= GoodCnt + 16'd1;
      if (badP && BadCnt != 16'hFFFF) BadCnt <= BadCnt + 16'd1;
      if (ovfP && OvfCnt != 16'hFFFF) OvfCnt <= OvfCnt + 16'd1;
    end
  end
`else
  logic unusedStats;
  assign unusedStats = goodP ^ badP;
  assign GoodCnt = '0;
  assign BadCnt = '0;
  assign OvfCnt = '0;
`endif
endmodule
